seq_multiplier: RTL and testbench
=================================

Name: seq_multiplier

Overview:
- Sequential unsigned shift-and-add integer multiplier: WIDTH x WIDTH operands in, 2*WIDTH product out.
- Processes one multiplier bit per clock.
- Sits beside the ALU as a multi-cycle functional unit, driven by a start/done handshake.

Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH bits.

Ports:
- clk     input   1        rising-edge clock
- rst_n   input   1        asynchronous active-low reset
- a       input   WIDTH    multiplicand, sampled on the start edge
- b       input   WIDTH    multiplier, sampled on the start edge
- start   input   1        request; sampled high on a rising clk edge while IDLE
- result  output  2*WIDTH  product; held stable until the next accepted start
- done    output  1        one-cycle pulse marking result valid

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (rst_n).
  - Asserting rst_n=0 at any time, including mid-operation, forces state IDLE, result=0, done=0, and clears internal registers and counter.
- States: IDLE, BUSY, DONE.
- IDLE, start=1 at a clk edge:
  - latch a into the multiplicand register, zero-extended to 2*WIDTH;
  - latch b into the multiplier shift register;
  - clear the accumulator and counter; go to BUSY.
- IDLE, start=0: stay in IDLE; result holds its previous value.
- BUSY, each edge:
  - if the multiplier LSB is 1, accumulator += multiplicand (2*WIDTH-bit add, no overflow possible);
  - multiplicand shifts left 1, multiplier shifts right 1, counter increments.
  - After the WIDTH-th BUSY edge, go to DONE.
- DONE edge:
  - result <= accumulator; done = 1 for exactly this one cycle; go to IDLE.
- Latency: start edge at cycle 0, done high during cycle WIDTH+1 (33 for WIDTH=32). The same value remains on result afterwards.
- start asserted while BUSY or DONE is ignored; no queuing.
- start held high continuously: a new operation is accepted on the first IDLE edge after DONE, using the a/b values present at that edge.
- a and b may change freely after the start edge without affecting the operation in flight.
- Zero operands still take the full WIDTH+1 cycles (fixed latency).
- result updates only in DONE.

Optional Feature:
- Macro MULT_SIGNED_EN.
- Defined:
  - a and b are two's complement.
  - On the start edge, latch the magnitudes, plus sign = a[WIDTH-1]^b[WIDTH-1].
  - In DONE, result is the accumulator negated when sign=1.
  - Latency unchanged.
  - Most-negative operands are handled: magnitude 2^(WIDTH-1) fits as unsigned.
- Undefined: pure unsigned operation as above, and no sign logic is synthesized.

Decomposition:
- Package mult_pkg holds:
  - state enum {IDLE, BUSY, DONE};
  - default WIDTH constant;
  - counter width constant $clog2(WIDTH+1).
- Natural sub-module: seq_mult_ctrl, containing the FSM and counter and producing load/step/finish strobes. The datapath (registers plus adder) stays in seq_multiplier.

Test Plan:
- a=0, b=0, start one cycle, then 40 idle clocks -> done pulses once at cycle 33; result=64'h0.
- a=3, b=5 -> result=64'd15; a=32'hFFFFFFFF, b=32'hFFFFFFFF -> result=64'hFFFFFFFE00000001.
- a=32'h80000000, b=2 -> result=64'h0000000100000000; then a=1, b=32'h12345678 -> result=64'h12345678, with the previous result held until the second done.
- Start with a=7, b=9; at cycle 10 pulse start again with a=2, b=2 and change a/b -> the second start is ignored; result=63 at cycle 33.
- rst_n low at cycle 15 of an operation -> done=0 and result=0 immediately (asynchronous). After release, a new start with a=6, b=7 -> result=42 after 33 cycles.
- With MULT_SIGNED_EN: a=-1, b=-1 -> 1; a=-3, b=5 -> 64'hFFFFFFFFFFFFFFF1; a=32'h80000000, b=32'h80000000 -> 64'h4000000000000000.

Source files
------------

// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the sequential shift-and-add multiplier.
//   mult_state_e  : controller state encoding (IDLE, BUSY, DONE)
//   DEFAULT_WIDTH : default operand width
//   cnt_width()   : bits needed for a counter that reaches WIDTH
//   CNT_W         : counter width for the default operand width
// -----------------------------------------------------------------------------
package mult_pkg;

  localparam int DEFAULT_WIDTH = 32;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int CNT_W = cnt_width(DEFAULT_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mult_state_e;

endpackage

// File: rtl/seq_mult_ctrl.sv
// -----------------------------------------------------------------------------
// seq_mult_ctrl
// Control FSM for the sequential multiplier. Counts WIDTH BUSY cycles and
// issues one-cycle strobes that steer the datapath in the parent.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : operation request, honoured only in IDLE
//   load_o     : capture operands this edge (IDLE and start)
//   step_o     : perform one shift-and-add iteration this edge (BUSY)
//   finish_o   : publish the product this edge (DONE)
//   state_o    : current FSM state, exported for observation
// -----------------------------------------------------------------------------
module seq_mult_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        load_o,
  output logic        step_o,
  output logic        finish_o,
  output mult_state_e state_o
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  mult_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load_o   = 1'b0;
    step_o   = 1'b0;
    finish_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load_o  = 1'b1;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        step_o = 1'b1;
        cnt_d  = cnt_q + CW'(1);
        // cnt_q holds the number of steps already taken, so this edge is
        // the WIDTH-th step when it equals WIDTH-1.
        if (cnt_q == LAST_STEP) begin
          state_d = DONE;
        end
      end
      DONE: begin
        finish_o = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign state_o = state_q;

endmodule

// File: rtl/seq_multiplier.sv
// -----------------------------------------------------------------------------
// seq_multiplier
// Sequential shift-and-add multiplier, one multiplier bit per clock.
// Fixed latency: start edge is cycle 0, done is high during cycle WIDTH+1.
//
// Handshake: start is sampled on a rising clk edge only while the unit is
// IDLE; requests made while BUSY or DONE are dropped (no queuing). done is a
// one-cycle pulse that coincides with result taking the new product; result
// then holds until the next accepted operation completes.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   a, b       : WIDTH-bit multiplicand / multiplier, sampled on start edge
//   start      : operation request
//   result     : 2*WIDTH-bit product
//   done       : product-valid pulse
//
// Build option: define MULT_SIGNED_EN for two's complement operands
// (magnitudes are multiplied and the product is negated when signs differ).
// Without it, operands are unsigned and no sign logic exists.
// -----------------------------------------------------------------------------
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               start,
  output logic [2*WIDTH-1:0] result,
  output logic               done
);

  localparam int PW = 2 * WIDTH;

  logic load, step, finish;
  // Controller state tap for observation; the datapath is driven by strobes.
  mult_state_e ctrl_state_unused;

  seq_mult_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .load_o   (load),
    .step_o   (step),
    .finish_o (finish),
    .state_o  (ctrl_state_unused)
  );

  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    result_q, result_d;
  logic             done_q, done_d;

  // Operand magnitudes entering the datapath and the product as published.
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [PW-1:0]    acc_final;

`ifdef MULT_SIGNED_EN
  logic sign_q, sign_d;

  // The most-negative operand negates to itself, whose unsigned reading
  // 2^(WIDTH-1) is exactly its magnitude, so no extra bit is needed.
  always_comb begin
    a_mag     = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
    b_mag     = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
    sign_d    = load ? (a[WIDTH-1] ^ b[WIDTH-1]) : sign_q;
    acc_final = sign_q ? (~acc_q + PW'(1)) : acc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q <= 1'b0;
    end else begin
      sign_q <= sign_d;
    end
  end
`else
  assign a_mag     = a;
  assign b_mag     = b;
  assign acc_final = acc_q;
`endif

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    result_d = result_q;
    done_d   = finish;
    if (load) begin
      mcand_d  = {{WIDTH{1'b0}}, a_mag};
      mplier_d = b_mag;
      acc_d    = '0;
    end else if (step) begin
      // Both operands are below 2^WIDTH, so the running sum fits in PW bits.
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end
    if (finish) begin
      result_d = acc_final;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// -----------------------------------------------------------------------------
// tb_seq_multiplier
// Directed testbench for seq_multiplier (WIDTH = 32). Inputs are driven on the
// falling edge or 1 time unit after a rising edge; outputs are sampled 1 time
// unit after a rising edge. Edge 0 is the start edge, so done is expected
// after edge 33.
// -----------------------------------------------------------------------------
module tb_seq_multiplier;

  localparam int W = 32;
  localparam int LATENCY = W + 1;

  logic           clk;
  logic           rst_n;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           start;
  logic [2*W-1:0] result;
  logic           done;

  int n_checks;
  int n_errors;
  logic [2*W-1:0] last_exp;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a),
    .b      (b),
    .start  (start),
    .result (result),
    .done   (done)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset();
    rst_n = 1'b0;
    a     = '0;
    b     = '0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b0) begin
      $display("FAIL reset_done: got %b expected 0", done);
      n_errors++;
    end
    n_checks++;
    if (result !== 64'h0) begin
      $display("FAIL reset_result: got %h expected 0", result);
      n_errors++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b0 || result !== 64'h0) begin
      $display("FAIL post_reset_idle: done=%b result=%h expected done=0 result=0", done, result);
      n_errors++;
    end
    last_exp = 64'h0;
  endtask

  // One operation with a single-cycle start pulse, observed for 40 edges.
  // Checks done latency, pulse count, held result before done, and result.
  task automatic do_mult(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [2*W-1:0] exp, input string name);
    int done_at;
    int pulses;
    bit held_ok;
    logic [2*W-1:0] res_at_done;
    done_at     = -1;
    pulses      = 0;
    held_ok     = 1'b1;
    res_at_done = 'x;
    @(negedge clk);
    a     = av;
    b     = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom();
    b     = $urandom();
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        pulses++;
        if (done_at < 0) begin
          done_at     = k;
          res_at_done = result;
        end
      end
      if (done_at < 0 && result !== last_exp) held_ok = 1'b0;
    end
    n_checks++;
    if (done_at != LATENCY) begin
      $display("FAIL %s_latency: done at edge %0d expected %0d", name, done_at, LATENCY);
      n_errors++;
    end
    n_checks++;
    if (pulses != 1) begin
      $display("FAIL %s_pulses: got %0d done pulses expected 1", name, pulses);
      n_errors++;
    end
    n_checks++;
    if (!held_ok) begin
      $display("FAIL %s_held: result changed before done, expected %h held", name, last_exp);
      n_errors++;
    end
    n_checks++;
    if (res_at_done !== exp || result !== exp) begin
      $display("FAIL %s_result: at done %h, after %h expected %h", name, res_at_done, result, exp);
      n_errors++;
    end
    last_exp = exp;
  endtask

  task automatic test_unsigned_basic();
    do_mult(32'd0, 32'd0, 64'h0, "zero");
    do_mult(32'd3, 32'd5, 64'd15, "three_five");
  endtask

  // Second start mid-operation must be ignored; a/b changes must not matter.
  task automatic test_ignore_start();
    int done_at;
    int pulses;
    logic [2*W-1:0] res_at_done;
    done_at     = -1;
    pulses      = 0;
    res_at_done = 'x;
    @(negedge clk);
    a     = 32'd7;
    b     = 32'd9;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        pulses++;
        if (done_at < 0) begin
          done_at     = k;
          res_at_done = result;
        end
      end
      if (k == 9) begin
        start = 1'b1;
        a     = 32'd2;
        b     = 32'd2;
      end
      if (k == 10) begin
        start = 1'b0;
        a     = 32'hDEAD_BEEF;
        b     = 32'h1234_5678;
      end
    end
    n_checks++;
    if (done_at != LATENCY || pulses != 1) begin
      $display("FAIL ignore_start_timing: done at %0d pulses %0d expected %0d and 1", done_at, pulses, LATENCY);
      n_errors++;
    end
    n_checks++;
    if (res_at_done !== 64'd63) begin
      $display("FAIL ignore_start_result: got %h expected %h", res_at_done, 64'd63);
      n_errors++;
    end
    last_exp = 64'd63;
  endtask

  // start held high: the next operation begins on the first IDLE edge after
  // DONE (edge 34) with the a/b present then; its done lands on edge 67.
  task automatic test_back_to_back();
    int first_at;
    int second_at;
    int pulses;
    logic [2*W-1:0] res1;
    logic [2*W-1:0] res2;
    first_at  = -1;
    second_at = -1;
    pulses    = 0;
    res1      = 'x;
    res2      = 'x;
    @(negedge clk);
    a     = 32'd3;
    b     = 32'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    a = 32'd6;
    b = 32'd7;
    for (int k = 1; k <= 72; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        pulses++;
        if (first_at < 0) begin
          first_at = k;
          res1     = result;
        end else if (second_at < 0) begin
          second_at = k;
          res2      = result;
        end
      end
      if (k == LATENCY + 1) start = 1'b0;
    end
    n_checks++;
    if (first_at != LATENCY || res1 !== 64'd15) begin
      $display("FAIL b2b_first: done at %0d result %h expected %0d and %h", first_at, res1, LATENCY, 64'd15);
      n_errors++;
    end
    n_checks++;
    if (second_at != 2 * LATENCY + 1 || res2 !== 64'd42) begin
      $display("FAIL b2b_second: done at %0d result %h expected %0d and %h", second_at, res2, 2 * LATENCY + 1, 64'd42);
      n_errors++;
    end
    n_checks++;
    if (pulses != 2) begin
      $display("FAIL b2b_pulses: got %0d expected 2", pulses);
      n_errors++;
    end
    last_exp = 64'd42;
  endtask

`ifdef MULT_SIGNED_EN
  task automatic test_signed();
    do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1, "neg1_neg1");
    do_mult(32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, "neg3_five");
    do_mult(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "minneg_sq");
    do_mult(32'd7, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFF2, "seven_neg2");
  endtask
`else
  task automatic test_unsigned_boundary();
    do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "max_max");
    do_mult(32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000, "msb_two");
    do_mult(32'd1, 32'h1234_5678, 64'h0000_0000_1234_5678, "one_pattern");
  endtask
`endif

  // Asynchronous reset in the middle of an operation, then a clean operation.
  task automatic test_reset_mid_op();
    @(negedge clk);
    a     = 32'd100;
    b     = 32'd100;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (done !== 1'b0) begin
      $display("FAIL midreset_done: got %b expected 0", done);
      n_errors++;
    end
    n_checks++;
    if (result !== 64'h0) begin
      $display("FAIL midreset_result: got %h expected 0", result);
      n_errors++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    last_exp = 64'h0;
    do_mult(32'd6, 32'd7, 64'd42, "after_reset");
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_unsigned_basic();
    test_ignore_start();
    test_back_to_back();
`ifdef MULT_SIGNED_EN
    test_signed();
`else
    test_unsigned_boundary();
`endif
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
